// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning active-low decoder: mode encoding and
// the per-output active-low one-hot decode helper.
package decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Widest select supported by the decode helper; the top zero-extends into it.
    localparam int MAX_N = 8;

    // Active-low one-hot decode, evaluated per output position.
    function automatic logic decode_low(input logic [MAX_N-1:0] sel,
                                        input logic [MAX_N-1:0] pos);
        decode_low = (sel != pos);
    endfunction

endpackage

// File: rtl/decoder_n_low_scan_tick_gen.sv
// Scan prescaler: counts 0..PRESCALE-1 while enabled and strobes on the
// terminal count so the owner can advance on that same clock edge.
module tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic stb
);
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          wrap_s;

    assign wrap_s = (cnt_r == LAST);
    // A clear always wins so a mode change never produces a strobe.
    assign stb    = en & ~clr & wrap_s;

    // Next prescaler count: clear, wrap at terminal count, or hold.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = {CW{1'b0}};
        end else if (en) begin
            cnt_s = wrap_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/decoder_n_low_scan.sv
// Active-low one-hot decoder with direct select and prescaled auto-scan.
// Build option DECODER_BLANK_EN adds a blank input that forces y high without disturbing the scan.
module decoder_n_low_scan
    import decoder_pkg::*;
#(
    parameter int N        = 2,
    parameter int PRESCALE = 4
) (
`ifdef DECODER_BLANK_EN
    input  logic                blank,
`endif
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        w,
    input  logic [N-1:0]        last,
    output logic [(2**N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                tick
);
    localparam int OUTS = 2 ** N;

    logic [N-1:0]    idx_r;
    logic [N-1:0]    idx_s;
    logic [OUTS-1:0] y_r;
    logic [OUTS-1:0] y_s;
    logic            tick_r;
    logic            tick_s;
    mode_e           mode_r;
    mode_e           mode_s;
    mode_e           mode_in_s;
    logic            chg_s;
    logic            clr_s;
    logic            gen_en_s;
    logic            stb_s;
    logic            blank_s;

`ifdef DECODER_BLANK_EN
    assign blank_s = blank;
`else
    assign blank_s = 1'b0;
`endif

    // Any mode change seen while enabled restarts the prescaler.
    assign mode_in_s = mode_e'(mode);
    assign chg_s     = (mode_in_s != mode_r);
    assign clr_s     = en & chg_s;
    assign gen_en_s  = en & (mode_in_s == MODE_SCAN);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .en  (gen_en_s),
        .stb (stb_s)
    );

    // Next index, stored mode and advance pulse.
    always_comb begin
        idx_s  = idx_r;
        mode_s = mode_r;
        tick_s = 1'b0;
        if (!en) begin
            idx_s = idx_r;
        end else if (mode_in_s == MODE_DIRECT) begin
            idx_s  = w;
            mode_s = MODE_DIRECT;
        end else if (chg_s) begin
            idx_s  = {N{1'b0}};
            mode_s = MODE_SCAN;
        end else if (stb_s) begin
            // >= so a shrunken last wraps instead of scanning past it.
            idx_s  = (idx_r >= last) ? {N{1'b0}} : idx_r + N'(1'b1);
            tick_s = 1'b1;
        end else begin
            idx_s = idx_r;
        end
    end

    // Decode the next index; disabled or blanked drives every output high.
    always_comb begin
        y_s = {OUTS{1'b1}};
        if (en && !blank_s) begin
            for (int i = 0; i < OUTS; i++) begin
                y_s[i] = decode_low(MAX_N'(idx_s), MAX_N'(i));
            end
        end else begin
            y_s = {OUTS{1'b1}};
        end
    end

    // Output and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r    <= {OUTS{1'b1}};
            idx_r  <= {N{1'b0}};
            tick_r <= 1'b0;
            mode_r <= MODE_DIRECT;
        end else begin
            y_r    <= y_s;
            idx_r  <= idx_s;
            tick_r <= tick_s;
            mode_r <= mode_s;
        end
    end

    assign y    = y_r;
    assign idx  = idx_r;
    assign tick = tick_r;

endmodule
